spi_id_responder: RTL and testbench

- SPI mode-0 target that emulates the JEDEC Read-ID response of a serial flash: it receives an 8-bit command, and for RDID (0x9F) it shifts out three programmable ID bytes.
- Used on the bench board as the far end of our SPI ID-read initiator, and as a loop-back target for bring-up without a real flash.
- All SPI pins are treated as asynchronous inputs and oversampled on clk12MHz.

---
 rtl/spi_id_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_id_responder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_id_responder.sv
// SPI mode-0 target answering the JEDEC Read-ID command with three
// programmable ID bytes. All SPI pins are oversampled on clk12MHz.
//
// Handshake: cmd_valid is a single-cycle strobe qualifying cmd_byte. There
// is no ready input; a consumer must take cmd_byte in the strobe cycle,
// although cmd_byte keeps its value until the next complete command.
// resp_done is a single-cycle strobe with no data attached.
module spi_id_responder #(
  parameter logic [7:0] CMD_RDID = 8'h9F,
  parameter logic [7:0] ID_BYTE0 = 8'hEF,
  parameter logic [7:0] ID_BYTE1 = 8'h40,
  parameter logic [7:0] ID_BYTE2 = 8'h18
) (
  input  logic       clk12MHz,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_oe,
  output logic [7:0] cmd_byte,
  output logic       cmd_valid,
  output logic       busy,
  output logic       resp_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RESP   = 2'd2,
    IGNORE = 2'd3
  } state_t;

  // state_q is the observable FSM state for checkers bound to this module
  state_t state_q;
  state_t state_d;

  // Synchroniser stages (s1, s2) plus a delay flop for edge detection.
  // sdi is sampled from s2, the same stage sck edges are detected on, so a
  // rising sck edge and its data bit are seen in the same cycle.
  logic sck_s1, sck_s2, sck_d;
  logic cs_s1, cs_s2, cs_d;
  logic sdi_s1, sdi_s2;

  // fill tracks when the cs synchroniser holds real pin samples after
  // reset; armed is set once cs has been seen high, so a cs already low at
  // reset release cannot start a transaction.
  logic [1:0] fill;
  logic       armed;

  logic sck_rise, sck_fall, cs_rise, cs_fall;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [7:0] cmd_shift_q, cmd_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       started_q, started_d;
  logic [7:0] cmd_byte_d;
  logic       cmd_valid_d;
  logic       resp_done_d;
  logic       sdo_d;
  logic       sdo_oe_d;
  logic [7:0] load_byte;

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = ID_BYTE0;
      2'd1:    id_byte = ID_BYTE1;
      default: id_byte = ID_BYTE2;
    endcase
  endfunction

  // Pin synchronisers, reset to the idle bus levels
  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_d  <= 1'b0;
      cs_s1  <= 1'b1;
      cs_s2  <= 1'b1;
      cs_d   <= 1'b1;
      sdi_s1 <= 1'b0;
      sdi_s2 <= 1'b0;
    end else begin
      sck_s1 <= sck;
      sck_s2 <= sck_s1;
      sck_d  <= sck_s2;
      cs_s1  <= cs;
      cs_s2  <= cs_s1;
      cs_d   <= cs_s2;
      sdi_s1 <= sdi;
      sdi_s2 <= sdi_s1;
    end
  end

  // Arm the start detector only after cs has genuinely been seen high
  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      fill <= {fill[0], 1'b1};
      if (fill[1] && cs_s2) begin
        armed <= 1'b1;
      end
    end
  end

  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;
  assign cs_rise  = cs_s2 & ~cs_d;
  assign cs_fall  = ~cs_s2 & cs_d;
  assign busy     = ~cs_s2;

  // FSM state register
  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next datapath values; cs rising wins over any sck edge
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    cmd_shift_d = cmd_shift_q;
    tx_shift_d  = tx_shift_q;
    started_d   = started_q;
    cmd_byte_d  = cmd_byte;
    cmd_valid_d = 1'b0;
    resp_done_d = 1'b0;
    sdo_d       = sdo;
    load_byte   = 8'h00;

    if (cs_rise) begin
      state_d    = IDLE;
      bit_cnt_d  = 3'd0;
      byte_idx_d = 2'd0;
      started_d  = 1'b0;
      sdo_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sdo_d = 1'b0;
          if (cs_fall && armed) begin
            state_d   = CMD;
            bit_cnt_d = 3'd0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            cmd_shift_d = {cmd_shift_q[6:0], sdi_s2};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              cmd_byte_d  = cmd_shift_d;
              cmd_valid_d = 1'b1;
              byte_idx_d  = 2'd0;
              started_d   = 1'b0;
              state_d     = (cmd_shift_d == CMD_RDID) ? RESP : IGNORE;
            end
          end
        end
        RESP: begin
          if (sck_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd0) begin
              // Byte boundary: load the next ID byte and drive its MSB.
              // Returning to byte 0 after a full pass marks completion.
              load_byte  = id_byte(byte_idx_q);
              sdo_d      = load_byte[7];
              tx_shift_d = {load_byte[6:0], 1'b0};
              byte_idx_d = (byte_idx_q == 2'd2) ? 2'd0 : byte_idx_q + 2'd1;
              started_d  = 1'b1;
              if (started_q && (byte_idx_q == 2'd0)) begin
                resp_done_d = 1'b1;
              end
            end else begin
              sdo_d      = tx_shift_q[7];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
          end
        end
        IGNORE: begin
          sdo_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          sdo_d   = 1'b0;
        end
      endcase
    end

    sdo_oe_d = (state_d == RESP);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= 3'd0;
      byte_idx_q  <= 2'd0;
      cmd_shift_q <= 8'h00;
      tx_shift_q  <= 8'h00;
      started_q   <= 1'b0;
      cmd_byte    <= 8'h00;
      cmd_valid   <= 1'b0;
      resp_done   <= 1'b0;
      sdo         <= 1'b0;
      sdo_oe      <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      cmd_shift_q <= cmd_shift_d;
      tx_shift_q  <= tx_shift_d;
      started_q   <= started_d;
      cmd_byte    <= cmd_byte_d;
      cmd_valid   <= cmd_valid_d;
      resp_done   <= resp_done_d;
      sdo         <= sdo_d;
      sdo_oe      <= sdo_oe_d;
    end
  end

endmodule

// File: tb/tb_spi_id_responder.sv
// Bench for spi_id_responder: a bit-banged mode-0 initiator drives two
// instances (default IDs and overridden IDs); expectations come from a
// simple model of the Read-ID protocol.
`timescale 1ns/1ps
module tb_spi_id_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sck = 1'b0;
  logic sdi = 1'b0;
  logic cs0 = 1'b1;
  logic cs1 = 1'b1;

  logic       sdo0, sdo_oe0, cmd_valid0, busy0, resp_done0;
  logic [7:0] cmd_byte0;
  logic       sdo1, sdo_oe1, cmd_valid1, busy1, resp_done1;
  logic [7:0] cmd_byte1;

  spi_id_responder dut0 (
    .clk12MHz (clk),
    .rst      (rst),
    .sck      (sck),
    .cs       (cs0),
    .sdi      (sdi),
    .sdo      (sdo0),
    .sdo_oe   (sdo_oe0),
    .cmd_byte (cmd_byte0),
    .cmd_valid(cmd_valid0),
    .busy     (busy0),
    .resp_done(resp_done0)
  );

  spi_id_responder #(
    .ID_BYTE0(8'hC2),
    .ID_BYTE1(8'h20),
    .ID_BYTE2(8'h17)
  ) dut1 (
    .clk12MHz (clk),
    .rst      (rst),
    .sck      (sck),
    .cs       (cs1),
    .sdi      (sdi),
    .sdo      (sdo1),
    .sdo_oe   (sdo_oe1),
    .cmd_byte (cmd_byte1),
    .cmd_valid(cmd_valid1),
    .busy     (busy1),
    .resp_done(resp_done1)
  );

  int   sel = 0;
  logic sdo_m, sdo_oe_m;
  assign sdo_m    = (sel == 1) ? sdo1 : sdo0;
  assign sdo_oe_m = (sel == 1) ? sdo_oe1 : sdo_oe0;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int oe_low_rises;

  // Event counters sampled away from the active edge
  int cv_cnt[2]   = '{0, 0};
  int rd_cnt[2]   = '{0, 0};
  int oe_cyc[2]   = '{0, 0};
  int sdo_cyc[2]  = '{0, 0};
  always @(negedge clk) begin
    if (cmd_valid0) cv_cnt[0]++;
    if (cmd_valid1) cv_cnt[1]++;
    if (resp_done0) rd_cnt[0]++;
    if (resp_done1) rd_cnt[1]++;
    if (sdo_oe0)    oe_cyc[0]++;
    if (sdo_oe1)    oe_cyc[1]++;
    if (sdo0)       sdo_cyc[0]++;
    if (sdo1)       sdo_cyc[1]++;
  end

  // Watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // Read-ID protocol: every 8 response clocks deliver one byte; the ID
  // bytes repeat in order for RDID, other commands leave the line at 0.
  // A completion strobe marks each finished 3-byte pass.
  function automatic logic [7:0] model_id(input int which, input int k);
    logic [7:0] ids_a[3];
    logic [7:0] ids_b[3];
    ids_a = '{8'hEF, 8'h40, 8'h18};
    ids_b = '{8'hC2, 8'h20, 8'h17};
    return (which == 1) ? ids_b[k % 3] : ids_a[k % 3];
  endfunction

  task automatic build_expect(input int which, input logic [7:0] cmd, input int n_resp);
    exp_q.delete();
    for (int k = 0; k < n_resp / 8; k++) begin
      exp_q.push_back((cmd == 8'h9F) ? model_id(which, k) : 8'h00);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cs(input int which, input logic v);
    if (which == 1) cs1 = v;
    else            cs0 = v;
  endtask

  // One transaction: cmd_bits of cmd, then n_resp response clocks with the
  // initiator capturing sdo at each rising sck. abort_at >= 0 stops after
  // that many response clocks, leaving cs low.
  task automatic spi_xfer(input int which, input logic [7:0] cmd, input int cmd_bits,
                          input int n_resp, input int hp, input int abort_at);
    logic [7:0] cur;
    int nb;
    rx_q.delete();
    oe_low_rises = 0;
    sel = which;
    set_cs(which, 1'b0);
    wait_clk(hp);
    for (int i = 0; i < cmd_bits; i++) begin
      sdi = cmd[7-i];
      wait_clk(hp);
      sck = 1'b1;
      wait_clk(hp);
      sck = 1'b0;
    end
    cur = 8'h00;
    nb  = 0;
    for (int i = 0; i < n_resp; i++) begin
      if (i == abort_at) return;
      sdi = 1'($urandom_range(0, 1));
      wait_clk(hp);
      cur = {cur[6:0], sdo_m};
      if (!sdo_oe_m) oe_low_rises++;
      sck = 1'b1;
      nb++;
      if (nb == 8) begin
        rx_q.push_back(cur);
        nb = 0;
      end
      wait_clk(hp);
      sck = 1'b0;
    end
    wait_clk(hp);
    set_cs(which, 1'b1);
    wait_clk(8);
  endtask

  // Full transaction plus checks of every observable against the model
  task automatic run_and_check(input string tag, input int which, input logic [7:0] cmd,
                               input int n_resp, input int hp);
    int cv_b, rd_b, oe_b, sdo_b, exp_rd;
    logic [7:0] cb;
    cv_b  = cv_cnt[which];
    rd_b  = rd_cnt[which];
    oe_b  = oe_cyc[which];
    sdo_b = sdo_cyc[which];
    build_expect(which, cmd, n_resp);
    exp_rd = (cmd == 8'h9F) ? n_resp / 24 : 0;
    spi_xfer(which, cmd, 8, n_resp, hp, -1);
    cb = (which == 1) ? cmd_byte1 : cmd_byte0;

    n_checks++;
    if (cv_cnt[which] - cv_b !== 1) $display("FAIL %s cmd_valid pulses got %0d exp 1", tag, cv_cnt[which] - cv_b);
    else n_pass++;
    n_checks++;
    if (cb !== cmd) $display("FAIL %s cmd_byte got %h exp %h", tag, cb, cmd);
    else n_pass++;
    n_checks++;
    if (rd_cnt[which] - rd_b !== exp_rd) $display("FAIL %s resp_done pulses got %0d exp %0d", tag, rd_cnt[which] - rd_b, exp_rd);
    else n_pass++;
    n_checks++;
    if (rx_q.size() !== exp_q.size()) $display("FAIL %s byte count got %0d exp %0d", tag, rx_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = rx_q.pop_front();
      n_checks++;
      if (g !== e) $display("FAIL %s rx byte got %h exp %h", tag, g, e);
      else n_pass++;
    end
    if (cmd == 8'h9F) begin
      n_checks++;
      if (oe_low_rises !== 0) $display("FAIL %s sdo_oe low at %0d capture edges exp 0", tag, oe_low_rises);
      else n_pass++;
    end else begin
      n_checks++;
      if (oe_cyc[which] - oe_b !== 0) $display("FAIL %s sdo_oe high cycles got %0d exp 0", tag, oe_cyc[which] - oe_b);
      else n_pass++;
      n_checks++;
      if (sdo_cyc[which] - sdo_b !== 0) $display("FAIL %s sdo high cycles got %0d exp 0", tag, sdo_cyc[which] - sdo_b);
      else n_pass++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [12:0] got0, got1;
    wait_clk(2);
    got0 = {sdo0, sdo_oe0, cmd_byte0, cmd_valid0, busy0, resp_done0};
    got1 = {sdo1, sdo_oe1, cmd_byte1, cmd_valid1, busy1, resp_done1};
    n_checks++;
    if (got0 !== 13'd0) $display("FAIL reset dut0 outputs got %h exp 0", got0);
    else n_pass++;
    n_checks++;
    if (got1 !== 13'd0) $display("FAIL reset dut1 outputs got %h exp 0", got1);
    else n_pass++;
    rst = 1'b0;
    wait_clk(6);
  endtask

  task automatic test_rdid_basic();
    run_and_check("rdid24", 0, 8'h9F, 24, 5);
  endtask

  task automatic test_rdid_wrap();
    run_and_check("rdid32", 0, 8'h9F, 32, 4);
  endtask

  task automatic test_other_cmd();
    run_and_check("cmd05", 0, 8'h05, 8, 5);
  endtask

  task automatic test_partial();
    int cv_b;
    cv_b = cv_cnt[0];
    spi_xfer(0, 8'h9F, 5, 0, 4, -1);
    n_checks++;
    if (cv_cnt[0] - cv_b !== 0) $display("FAIL partial cmd_valid pulses got %0d exp 0", cv_cnt[0] - cv_b);
    else n_pass++;
    n_checks++;
    if (cmd_byte0 !== 8'h05) $display("FAIL partial cmd_byte held got %h exp 05", cmd_byte0);
    else n_pass++;
    run_and_check("after_partial", 0, 8'h9F, 24, 4);
  endtask

  task automatic test_reset_mid();
    int cv_b;
    logic [12:0] got;
    spi_xfer(0, 8'h9F, 8, 24, 4, 12);
    n_checks++;
    if (busy0 !== 1'b1) $display("FAIL busy mid transaction got %b exp 1", busy0);
    else n_pass++;
    rst = 1'b1;
    wait_clk(1);
    got = {sdo0, sdo_oe0, cmd_byte0, cmd_valid0, busy0, resp_done0};
    n_checks++;
    if (got !== 13'd0) $display("FAIL midreset outputs got %h exp 0", got);
    else n_pass++;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(6);
    // cs still low since before reset: a full command must be ignored
    cv_b = cv_cnt[0];
    for (int i = 0; i < 8; i++) begin
      sdi = (i == 0 || i >= 3) ? 1'b1 : 1'b0;
      wait_clk(4);
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
    end
    wait_clk(6);
    n_checks++;
    if (cv_cnt[0] - cv_b !== 0) $display("FAIL no_start cmd_valid pulses got %0d exp 0", cv_cnt[0] - cv_b);
    else n_pass++;
    n_checks++;
    if ({sdo_oe0, cmd_byte0} !== 9'd0) $display("FAIL no_start oe/cmd_byte got %h exp 0", {sdo_oe0, cmd_byte0});
    else n_pass++;
    cs0 = 1'b1;
    wait_clk(8);
    run_and_check("after_reset", 0, 8'h9F, 24, 5);
  endtask

  task automatic test_params();
    run_and_check("params_fast", 1, 8'h9F, 24, 4);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [7:0] cmd;
      int which, hp, n;
      which = $urandom_range(0, 1);
      hp    = $urandom_range(4, 7);
      if ($urandom_range(0, 1) == 1) begin
        cmd = 8'h9F;
        n   = $urandom_range(0, 56);
      end else begin
        cmd = 8'($urandom_range(0, 255));
        if (cmd == 8'h9F) cmd = 8'h9E;
        n = $urandom_range(0, 24);
      end
      run_and_check("random", which, cmd, n, hp);
    end
  endtask

  task automatic test_back_to_back();
    run_and_check("b2b_a", 1, 8'h9F, 48, 4);
    run_and_check("b2b_b", 0, 8'h9F, 16, 4);
  endtask

  initial begin
    test_reset();
    test_rdid_basic();
    test_rdid_wrap();
    test_other_cmd();
    test_partial();
    test_reset_mid();
    test_params();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
